// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ converter-side responder.
// Holds the sequencing state enum, frame/data widths and the default
// DAC command nibble used by daq_converter_if and its sub-modules.
package daq_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 12;
    localparam int CMD_W   = FRAME_W - DATA_W;

    localparam logic [CMD_W-1:0] DAC_CMD_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        DAC_FRAME,
        ADC_FRAME,
        GUARD,
        DONE
    } daq_state_t;

endpackage

// File: rtl/daq_converter_if_if.sv
// Handshake and serial-bus bundle between the DAQ controller, this
// responder and the external converters.
//   dac_en/dac_data/adc_en        : requests from the controller
//   dac_done/adc_done/adc_data    : completion back to the controller
//   sclk/mosi/dac_cs_n/adc_cs_n   : serial bus driven towards the devices
//   miso                          : serial data returned by the ADC
// slave  = responder view (daq_converter_if)
// master = controller/device view (drives requests and miso)
interface daq_converter_if_if;
    import daq_pkg::*;

    logic              dac_en;
    logic [DATA_W-1:0] dac_data;
    logic              adc_en;
    logic              dac_done;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;
    logic              sclk;
    logic              mosi;
    logic              dac_cs_n;
    logic              adc_cs_n;
    logic              miso;

    modport slave (
        input  dac_en, dac_data, adc_en, miso,
        output dac_done, adc_done, adc_data, sclk, mosi, dac_cs_n, adc_cs_n
    );

    modport master (
        output dac_en, dac_data, adc_en, miso,
        input  dac_done, adc_done, adc_data, sclk, mosi, dac_cs_n, adc_cs_n
    );

endinterface

// File: rtl/daq_sclk_gen.sv
// Serial clock generator for one 16-period frame.
//   clk, reset_n : system clock, synchronous active-low reset
//   en           : high while a frame is in progress; low parks sclk at 0
//   sclk         : serial clock, CLK_DIV clk cycles per half-period
//   rise         : first cycle in which sclk is high
//   fall_nx      : sclk falls at the next clk edge
//   last         : fall_nx of the 16th period (frame ends at next edge)
module daq_sclk_gen
    import daq_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall_nx,
    output logic last
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int PER_W = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(FRAME_W - 1);

    logic [CNT_W-1:0] cnt;
    logic [PER_W-1:0] per;
    logic             sclk_q;

    assign sclk    = sclk_q;
    assign fall_nx = en && sclk_q && (cnt == '0);
    assign rise    = en && sclk_q && (cnt == RELOAD);
    assign last    = fall_nx && (per == PER_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n || !en) begin
            cnt    <= RELOAD;
            per    <= '0;
            sclk_q <= 1'b0;
        end else if (cnt == '0) begin
            cnt    <= RELOAD;
            sclk_q <= ~sclk_q;
            if (sclk_q)
                per <= per + 1'b1;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/daq_converter_if.sv
// Converter-side responder for the DAQ sequencing handshake. Each rising
// edge of dac_en / adc_en becomes one 16-bit MSB-first frame on a shared
// SPI-style bus with separate chip selects. DAC has priority; an edge that
// arrives while busy is remembered in a one-deep pending flag per channel.
//   clk, reset_n : system clock, synchronous active-low reset
//   bus          : daq_converter_if_if.slave (handshake + serial bus)
//   overrun      : only with DAQ_IF_OVERRUN_EN defined; sticky flag set when
//                  an edge arrives for a channel that is already pending
//
// state     | meaning
// IDLE      | waiting; shadow tracks dac_data
// DAC_FRAME | dac_cs_n low, 16 sclk periods shifting {DAC_CMD, shadow}
// ADC_FRAME | adc_cs_n low, 16 sclk periods sampling miso
// GUARD     | both chip selects high for CLK_DIV cycles
// DONE      | one cycle, done pulse for the channel just served
module daq_converter_if
    import daq_pkg::*;
#(
    parameter int               CLK_DIV = 4,
    parameter logic [CMD_W-1:0] DAC_CMD = DAC_CMD_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    daq_converter_if_if.slave bus
`ifdef DAQ_IF_OVERRUN_EN
    ,
    output logic overrun
`endif
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] GUARD_RELOAD = CNT_W'(CLK_DIV - 1);

    daq_state_t state_q, state_nx;

    logic               dac_en_q, adc_en_q, dac_req, adc_req;
    logic               dac_pend, adc_pend, dac_start, adc_start;
    logic               cur_adc, in_frame;
    logic [DATA_W-1:0]  shadow, adc_data_q;
    logic [FRAME_W-1:0] sh;
    logic [CNT_W-1:0]   guard_cnt;
    logic               mosi_q, dac_cs_n_q, adc_cs_n_q, dac_done_q, adc_done_q;
    logic               sclk_rise, sclk_fall_nx, sclk_last;

    assign dac_req  = bus.dac_en && !dac_en_q;
    assign adc_req  = bus.adc_en && !adc_en_q;
    assign in_frame = (state_q == DAC_FRAME) || (state_q == ADC_FRAME);

    daq_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (in_frame),
        .sclk    (bus.sclk),
        .rise    (sclk_rise),
        .fall_nx (sclk_fall_nx),
        .last    (sclk_last)
    );

    always_comb begin
        state_nx  = state_q;
        dac_start = 1'b0;
        adc_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (dac_req || dac_pend) begin
                    dac_start = 1'b1;
                    state_nx  = DAC_FRAME;
                end else if (adc_req || adc_pend) begin
                    adc_start = 1'b1;
                    state_nx  = ADC_FRAME;
                end
            end
            DAC_FRAME, ADC_FRAME: if (sclk_last) state_nx = GUARD;
            GUARD:                if (guard_cnt == '0) state_nx = DONE;
            DONE:                 state_nx = IDLE;
            default:              state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            dac_en_q   <= 1'b0;
            adc_en_q   <= 1'b0;
            dac_pend   <= 1'b0;
            adc_pend   <= 1'b0;
            shadow     <= '0;
            sh         <= '0;
            cur_adc    <= 1'b0;
            guard_cnt  <= GUARD_RELOAD;
            mosi_q     <= 1'b0;
            dac_cs_n_q <= 1'b1;
            adc_cs_n_q <= 1'b1;
            dac_done_q <= 1'b0;
            adc_done_q <= 1'b0;
            adc_data_q <= '0;
        end else begin
            state_q  <= state_nx;
            dac_en_q <= bus.dac_en;
            adc_en_q <= bus.adc_en;
            // A start consumes the pending flag; a fresh edge in the same
            // cycle as a pending-driven start stays queued.
            dac_pend <= dac_start ? (dac_pend && dac_req) : (dac_pend || dac_req);
            adc_pend <= adc_start ? (adc_pend && adc_req) : (adc_pend || adc_req);

            if (state_q == IDLE)
                shadow <= bus.dac_data;

            guard_cnt <= (state_q == GUARD) ? guard_cnt - 1'b1 : GUARD_RELOAD;

            if (dac_start) begin
                sh      <= {DAC_CMD, shadow};
                mosi_q  <= DAC_CMD[CMD_W-1];
                cur_adc <= 1'b0;
            end else if (adc_start) begin
                sh      <= '0;
                cur_adc <= 1'b1;
            end else if (state_q == DAC_FRAME && sclk_fall_nx) begin
                sh     <= sh << 1;
                mosi_q <= sclk_last ? 1'b0 : sh[FRAME_W-2];
            end else if (state_q == ADC_FRAME && sclk_rise) begin
                sh <= {sh[FRAME_W-2:0], bus.miso};
            end

            // Outputs are registered from the next state so they line up
            // with the state they describe.
            dac_cs_n_q <= (state_nx != DAC_FRAME);
            adc_cs_n_q <= (state_nx != ADC_FRAME);
            dac_done_q <= (state_nx == DONE) && !cur_adc;
            adc_done_q <= (state_nx == DONE) && cur_adc;
            if (state_nx == DONE && cur_adc)
                adc_data_q <= sh[DATA_W-1:0];
        end
    end

    assign bus.mosi     = mosi_q;
    assign bus.dac_cs_n = dac_cs_n_q;
    assign bus.adc_cs_n = adc_cs_n_q;
    assign bus.dac_done = dac_done_q;
    assign bus.adc_done = adc_done_q;
    assign bus.adc_data = adc_data_q;

`ifdef DAQ_IF_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (!reset_n)
            overrun_q <= 1'b0;
        else if ((dac_req && dac_pend) || (adc_req && adc_pend))
            overrun_q <= 1'b1;
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_daq_converter_if.sv
module tb_daq_converter_if;

    localparam int CLK_DIV = 4;
    localparam int LAT     = 1 + 33 * CLK_DIV;

    typedef struct {
        bit          is_adc;
        logic [15:0] word;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
`ifdef DAQ_IF_OVERRUN_EN
    logic overrun;
`endif

    daq_converter_if_if bus();

    daq_converter_if #(.CLK_DIV(CLK_DIV), .DAC_CMD(4'b0011)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DAQ_IF_OVERRUN_EN
        ,
        .overrun (overrun)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_dac_done = 0;
    int   n_adc_done = 0;
    int   adc_frames = 0;
    exp_t sb[$];

    logic [15:0] adc_word = 16'h0;
    logic [15:0] dac_cap = 16'h0;
    int          miso_idx = 0;
    logic        sclk_p = 1'b0, mosi_p = 1'b0, dac_cs_n_p = 1'b1, adc_cs_n_p = 1'b1;
    logic        dac_done_p = 1'b0, adc_done_p = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bus monitor, ADC device model and scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            check("cs_overlap", 32'(bus.dac_cs_n | bus.adc_cs_n), 32'd1);
            if (dac_cs_n_p && !bus.dac_cs_n) begin
                dac_cap = 16'h0;
                if (sb.size() > 0)
                    check("mosi_msb", 32'(bus.mosi), 32'(sb[0].word[15]));
            end
            if (!dac_cs_n_p && !bus.dac_cs_n && (bus.mosi !== mosi_p))
                check("mosi_change_on_fall", {30'd0, sclk_p, bus.sclk}, 32'd2);
            if (!dac_cs_n_p && bus.dac_cs_n)
                check("mosi_idle", 32'(bus.mosi), 32'd0);
            if (bus.sclk && !sclk_p) begin
                if (!bus.dac_cs_n) dac_cap = {dac_cap[14:0], bus.mosi};
                if (!bus.adc_cs_n) check("adc_mosi_zero", 32'(bus.mosi), 32'd0);
            end
            if (adc_cs_n_p && !bus.adc_cs_n) begin
                adc_frames++;
                miso_idx = 15;
                bus.miso = adc_word[miso_idx];
            end else if (!bus.adc_cs_n && sclk_p && !bus.sclk && miso_idx > 0) begin
                miso_idx--;
                bus.miso = adc_word[miso_idx];
            end
            if (bus.dac_done) begin
                n_dac_done++;
                check("dac_done_width", 32'(dac_done_p), 32'd0);
            end
            if (bus.adc_done) begin
                n_adc_done++;
                check("adc_done_width", 32'(adc_done_p), 32'd0);
            end
            if (bus.dac_done || bus.adc_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {30'd0, bus.dac_done, bus.adc_done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_kind", {30'd0, bus.dac_done, bus.adc_done},
                          e.is_adc ? 32'd1 : 32'd2);
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    if (e.is_adc)
                        check("adc_data", 32'(bus.adc_data), {20'd0, e.word[11:0]});
                    else
                        check("dac_frame", 32'(dac_cap), {16'd0, e.word});
                end
            end
        end
        sclk_p     = bus.sclk;
        mosi_p     = bus.mosi;
        dac_cs_n_p = bus.dac_cs_n;
        adc_cs_n_p = bus.adc_cs_n;
        dac_done_p = bus.dac_done;
        adc_done_p = bus.adc_done;
    end

    task automatic push(input bit is_adc, input logic [15:0] word, input int done_cyc);
        exp_t e;
        e.is_adc   = is_adc;
        e.word     = word;
        e.done_cyc = done_cyc;
        sb.push_back(e);
    endtask

    // DAC request with data valid only in the cycle before the edge.
    task automatic dac_request(input logic [11:0] d, output int t);
        @(negedge clk);
        bus.dac_data = d;
        @(negedge clk);
        bus.dac_en   = 1'b1;
        bus.dac_data = ~d;
        t = cyc;
        push(1'b0, {4'b0011, d}, t + LAT);
        repeat (3) @(negedge clk);
        bus.dac_en = 1'b0;
    endtask

    task automatic adc_request(input logic [15:0] w, output int t);
        @(negedge clk);
        adc_word   = w;
        bus.adc_en = 1'b1;
        t = cyc;
        push(1'b1, w, t + LAT);
        repeat (3) @(negedge clk);
        bus.adc_en = 1'b0;
    endtask

    initial begin
        int t;
        int d0, a0;
        reset_n      = 1'b0;
        bus.dac_en   = 1'b0;
        bus.adc_en   = 1'b0;
        bus.dac_data = 12'h0;
        bus.miso     = 1'b0;

        // Reset
        repeat (5) begin
            @(negedge clk);
            check("rst_dac_cs_n", 32'(bus.dac_cs_n), 32'd1);
            check("rst_adc_cs_n", 32'(bus.adc_cs_n), 32'd1);
        end
        check("rst_sclk", 32'(bus.sclk), 32'd0);
        check("rst_mosi", 32'(bus.mosi), 32'd0);
        check("rst_dones", {30'd0, bus.dac_done, bus.adc_done}, 32'd0);
        check("rst_adc_data", 32'(bus.adc_data), 32'd0);
`ifdef DAQ_IF_OVERRUN_EN
        check("rst_overrun", 32'(overrun), 32'd0);
`endif
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // DAC write
        dac_request(12'hA5C, t);
        repeat (LAT + 10) @(negedge clk);
        check("dac1_drain", 32'(sb.size()), 32'd0);
        check("dac1_no_adc_cs", 32'(adc_frames), 32'd0);

        // ADC reads, including non-zero leading bits that must be dropped
        adc_request(16'h07E1, t);
        repeat (LAT + 10) @(negedge clk);
        check("adc1_drain", 32'(sb.size()), 32'd0);
        repeat (5) @(negedge clk);
        check("adc1_hold", 32'(bus.adc_data), 32'h7E1);
        adc_request(16'hF123, t);
        repeat (LAT + 10) @(negedge clk);
        check("adc2_drain", 32'(sb.size()), 32'd0);

        // Simultaneous requests: DAC first, ADC taken after DONE
        d0 = n_dac_done;
        a0 = n_adc_done;
        @(negedge clk);
        bus.dac_data = 12'h123;
        adc_word     = 16'h0456;
        @(negedge clk);
        bus.dac_en = 1'b1;
        bus.adc_en = 1'b1;
        t = cyc;
        push(1'b0, 16'h3123, t + LAT);
        push(1'b1, 16'h0456, t + 1 + 2 * LAT);
        repeat (3) @(negedge clk);
        bus.dac_en = 1'b0;
        bus.adc_en = 1'b0;
        repeat (2 * LAT + 20) @(negedge clk);
        check("simul_drain", 32'(sb.size()), 32'd0);
        check("simul_dac_count", 32'(n_dac_done - d0), 32'd1);
        check("simul_adc_count", 32'(n_adc_done - a0), 32'd1);

        // Reset in the middle of a DAC frame
        d0 = n_dac_done;
        @(negedge clk);
        bus.dac_data = 12'h777;
        @(negedge clk);
        bus.dac_en = 1'b1;
        t = cyc;
        repeat (3) @(negedge clk);
        bus.dac_en = 1'b0;
        while (cyc < t + 50) @(negedge clk);
        check("abort_cs_low_before", 32'(bus.dac_cs_n), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_dac_cs_n", 32'(bus.dac_cs_n), 32'd1);
        check("abort_sclk", 32'(bus.sclk), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 20) @(negedge clk);
        check("abort_no_done", 32'(n_dac_done - d0), 32'd0);
        dac_request(12'h5A5, t);
        repeat (LAT + 10) @(negedge clk);
        check("after_abort_drain", 32'(sb.size()), 32'd0);

        // Held-high enable produces exactly one frame
        d0 = n_dac_done;
        @(negedge clk);
        bus.dac_data = 12'h0F0;
        @(negedge clk);
        bus.dac_en = 1'b1;
        t = cyc;
        push(1'b0, 16'h30F0, t + LAT);
        repeat (400) @(negedge clk);
        bus.dac_en = 1'b0;
        repeat (20) @(negedge clk);
        check("held_drain", 32'(sb.size()), 32'd0);
        check("held_one_frame", 32'(n_dac_done - d0), 32'd1);

`ifdef DAQ_IF_OVERRUN_EN
        // Three ADC edges during one busy DAC frame
        check("ovr_clear", 32'(overrun), 32'd0);
        dac_request(12'h246, t);
        adc_word = 16'h0321;
        push(1'b1, 16'h0321, t + 1 + 2 * LAT);
        repeat (3) begin
            bus.adc_en = 1'b1;
            repeat (2) @(negedge clk);
            bus.adc_en = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("ovr_set", 32'(overrun), 32'd1);
        repeat (2 * LAT + 20) @(negedge clk);
        check("ovr_drain", 32'(sb.size()), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ovr_reset", 32'(overrun), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
